imem_boot_loader: RTL and testbench
===================================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024: instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter AW, default 10: word-address width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1: one-cycle load request.
REQ-006 The block SHALL have port host_valid, input, 1: the host word is valid.
REQ-007 The block SHALL have port host_data, input, 32: the program word.
REQ-008 The block SHALL have port host_last, input, 1: the current word is the final program word.
REQ-009 The block SHALL have port host_ready, output, 1: the loader accepts a word this cycle.
REQ-010 The block SHALL have port fetch_addr, input, 32: the core PC byte address.
REQ-011 The block SHALL have port imem_we, output, 1: the instruction memory write strobe.
REQ-012 The block SHALL have port imem_addr, output, AW: the instruction memory word address.
REQ-013 The block SHALL have port imem_wdata, output, 32: the instruction memory write data.
REQ-014 The block SHALL have port core_rst_n, output, 1: the core reset; 0 holds the core in reset.
REQ-015 The block SHALL have port busy, output, 1: a load is in progress.
REQ-016 The block SHALL have port err, output, 1: the image overflowed DEPTH.
REQ-017 The block SHALL have port word_count, output, AW+1: the number of words written by the last load.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, RUN and ERR.
REQ-019 In IDLE, the block SHALL drive core_rst_n=0 and host_ready=0; start=1 SHALL move the FSM to LOAD and clear the address counter and word_count.
REQ-020 In LOAD, the block SHALL drive host_ready=1, busy=1 and core_rst_n=0.
REQ-021 In LOAD, a handshake (host_valid & host_ready) SHALL assert imem_we combinationally in the same cycle, with imem_addr=counter and imem_wdata=host_data.
REQ-022 On each handshake, the counter and word_count SHALL increment at the clock edge.
REQ-023 A handshake with host_last=1 SHALL move the FSM to RUN; core_rst_n SHALL rise in the first cycle after that handshake.
REQ-024 A handshake at counter=DEPTH-1 with host_last=0 SHALL write the word, then move the FSM to ERR.
REQ-025 A handshake with host_last=1 at counter=DEPTH-1 SHALL move the FSM to RUN, not ERR.
REQ-026 In ERR, the block SHALL drive err=1, core_rst_n=0 and host_ready=0.
REQ-027 In RUN, the block SHALL drive core_rst_n=1, imem_we=0 and imem_addr=fetch_addr[AW+1:2], combinationally.
REQ-028 In RUN, fetch_addr bits above AW+1 SHALL be ignored.
REQ-029 start=1 in RUN or ERR SHALL move the FSM to LOAD and clear err, the counter and word_count; core_rst_n SHALL fall in the same cycle the FSM enters LOAD.
REQ-030 start=1 in LOAD SHALL be ignored.
REQ-031 start=1 and a handshake in the same cycle SHALL be possible only in LOAD, where start is ignored and the handshake completes normally.
REQ-032 In any non-LOAD state, the block SHALL drive imem_we=0, and host_valid SHALL have no effect.
REQ-033 The block SHALL have no address wrap-around: the counter never exceeds DEPTH.
REQ-034 In IDLE and ERR, the block SHALL drive imem_addr=counter.

Reset
REQ-035 rst=0 SHALL asynchronously force: state=IDLE, counter=0, word_count=0, err=0, busy=0, host_ready=0, imem_we=0, core_rst_n=0.
REQ-036 Reset asserted mid-LOAD SHALL abort the load; after release, the block SHALL require a new start to load.
REQ-037 Only the registered state, counter, word_count and err SHALL be reset; all outputs SHALL be derived from those registers.

Structure
REQ-038 The state encoding (IDLE=0, LOAD=1, RUN=2, ERR=3) and the DEPTH/AW defaults SHALL reside in the shared processor package.
REQ-039 The block SHALL be a single module with no sub-modules.
REQ-040 The block SHALL drive the write port of the instruction memory, and the instruction memory SHALL gain a matching synchronous write port (we, waddr, wdata).

Verification
REQ-041 Verification SHALL cover a basic load: after reset, start, then 3 words 0x02000493, 0x0094A023 and 0x0004A303, the last with host_last -> imem_we is pulsed at addresses 0, 1, 2; word_count=3; core_rst_n=1 one cycle after the 3rd handshake.
REQ-042 Verification SHALL cover backpressure gaps: host_valid toggling 1,0,0,1 -> exactly 2 writes, at addresses 0 and 1, with no write in the idle cycles.
REQ-043 Verification SHALL cover overflow: with DEPTH=4, 4 words and no host_last -> 4 writes, then err=1, core_rst_n=0, host_ready=0; a following start clears err and enters LOAD.
REQ-044 Verification SHALL cover exact fill: with DEPTH=4, 4 words with host_last on the 4th -> RUN, err=0, word_count=4.
REQ-045 Verification SHALL cover the run mux and re-load: in RUN, fetch_addr=0x0000_1008 -> imem_addr=2; then start -> core_rst_n=0 in the same cycle the FSM enters LOAD.
REQ-046 Verification SHALL cover reset mid-load: rst=0 after 2 handshakes -> immediate IDLE, word_count=0; host_valid without start then produces no write.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the default memory geometry and the loader FSM state encoding so
// that the loader, the instruction memory and the testbench agree on them.
package imem_boot_loader_pkg;

    // Default instruction memory geometry: depth in 32-bit words and the
    // matching word-address width (log2 of the depth).
    localparam int IMEM_DEPTH = 1024;
    localparam int IMEM_AW    = 10;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // after reset; core held in reset, waiting for start
        LOAD = 2'd1,   // accepting program words from the host
        RUN  = 2'd2,   // image loaded; core released and fetching
        ERR  = 2'd3    // image did not fit; core held in reset
    } load_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host-to-loader program word stream.
//   host_valid : host presents a program word
//   host_data  : 32-bit program word
//   host_last  : the presented word is the final word of the image
//   host_ready : loader accepts a word this cycle
// A word transfers on any cycle where host_valid and host_ready are both 1.
// master = the host side, slave = the loader side.
interface imem_boot_loader_if;

    logic        host_valid;
    logic [31:0] host_data;
    logic        host_last;
    logic        host_ready;

    modport master (
        output host_valid,
        output host_data,
        output host_last,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        input  host_last,
        output host_ready
    );

endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Streams a program image from a host into the instruction memory write port
// while holding the core in reset, then releases the core and hands the
// memory address port over to the core's fetch address.
// Ports:
//   clk, rst      : clock; asynchronous active-low reset
//   start         : one-cycle load request (ignored while loading)
//   host          : program word stream (slave side)
//   fetch_addr    : core PC byte address, used as the memory address in RUN
//   imem_we       : instruction memory write strobe
//   imem_addr     : instruction memory word address
//   imem_wdata    : instruction memory write data
//   core_rst_n    : core reset, 0 holds the core in reset
//   busy          : a load is in progress
//   err           : the last image overflowed the memory
//   word_count    : number of words written by the last load
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_loader_if.slave   host,
    input  logic [31:0]         fetch_addr,
    output logic                imem_we,
    output logic [AW-1:0]       imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_rst_n,
    output logic                busy,
    output logic                err,
    output logic [AW:0]         word_count
);

    // Counter value of the last word that fits in the memory.
    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

    load_state_t state;
    logic [AW:0] counter;
    logic [AW:0] words;
    logic        err_q;
    logic        handshake;

    // Only bits [AW+1:2] of the byte address select a word; the rest are
    // deliberately ignored.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};

    assign handshake = (state == LOAD) && host.host_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; only control registers are reset, the
    // image itself lives in the memory and needs no reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
            words   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        counter <= '0;
                        words   <= '0;
                    end
                end
                LOAD: begin
                    // start is ignored here; only handshakes advance.
                    if (handshake) begin
                        counter <= counter + 1'b1;
                        words   <= words + 1'b1;
                        // host_last wins over overflow on the final slot.
                        if (host.host_last) begin
                            state <= RUN;
                        end else if (counter == LAST_ADDR) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN, ERR: begin
                    if (start) begin
                        state   <= LOAD;
                        counter <= '0;
                        words   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of the registers above (plus the live
    // handshake for the write strobe), so reset forces them all at once.
    assign host.host_ready = (state == LOAD);
    assign busy            = (state == LOAD);
    assign core_rst_n      = (state == RUN);
    assign err             = err_q;
    assign word_count      = words;
    assign imem_we         = handshake;
    assign imem_wdata      = host.host_data;

    // NOTE: always_comb assigns a default first so no path leaves the output
    // unassigned and no latch is inferred.
    always_comb begin
        imem_addr = counter[AW-1:0];
        if (state == RUN) begin
            imem_addr = fetch_addr[AW+1:2];
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader, built with DEPTH=4 so that
// overflow and exact-fill cases are short. A directed vector table covers
// the basic load, backpressure, run mux, re-load, overflow and exact fill;
// a hand-written sequence covers reset in the middle of a load; a random
// phase is checked against a behavioural model of the loader.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   fetch_addr;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          err;
    logic [AW:0]   word_count;

    imem_boot_loader_if host_if ();

    imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .host       (host_if),
        .fetch_addr (fetch_addr),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          start;
        bit          valid;
        bit          last;
        logic [31:0] data;
        logic [31:0] fetch;
        bit          we;
        int          addr;
        bit          ready;
        bit          busy;
        bit          err;
        bit          core;
        int          wc;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(bit s, bit v, bit l, logic [31:0] d, logic [31:0] f,
                                bit we, int a, bit rdy, bit bsy, bit er, bit cr, int wc);
        vec_t r;
        r.start = s;  r.valid = v;  r.last = l;  r.data = d;  r.fetch = f;
        r.we = we;    r.addr = a;   r.ready = rdy; r.busy = bsy;
        r.err = er;   r.core = cr;  r.wc = wc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit we, input int addr,
                              input logic [31:0] wdata, input bit ready, input bit bsy,
                              input bit er, input bit core, input int wc);
        check({tag, ".imem_we"},    32'(imem_we),          32'(we));
        check({tag, ".imem_addr"},  32'(imem_addr),        32'(addr));
        check({tag, ".host_ready"}, 32'(host_if.host_ready), 32'(ready));
        check({tag, ".busy"},       32'(busy),             32'(bsy));
        check({tag, ".err"},        32'(err),              32'(er));
        check({tag, ".core_rst_n"}, 32'(core_rst_n),       32'(core));
        check({tag, ".word_count"}, 32'(word_count),       32'(wc));
        if (we) check({tag, ".imem_wdata"}, imem_wdata, wdata);
    endtask

    task automatic drive(input bit s, input bit v, input bit l,
                         input logic [31:0] d, input logic [31:0] f);
        start              = s;
        host_if.host_valid = v;
        host_if.host_last  = l;
        host_if.host_data  = d;
        fetch_addr         = f;
    endtask

    // Drive one vector just after a rising edge, compare on the falling
    // edge, then advance to just past the next rising edge.
    task automatic apply(input string tag, input vec_t v);
        drive(v.start, v.valid, v.last, v.data, v.fetch);
        @(negedge clk);
        check_outs(tag, v.we, v.addr, v.data, v.ready, v.busy, v.err, v.core, v.wc);
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the loader: which phase it is in and how many
    // words the current image has taken so far.
    bit m_loading, m_running, m_errored;
    int m_n;

    initial begin
        //          s  v  l  data          fetch           we a rdy bsy er cr wc
        vecs[0]  = mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 32'h02000493, 32'h0,        1, 0, 1, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 32'h0094A023, 32'h0,        1, 1, 1, 1, 0, 0, 1);
        vecs[3]  = mk(0, 1, 1, 32'h0004A303, 32'h0,        1, 2, 1, 1, 0, 0, 2);
        vecs[4]  = mk(0, 1, 0, 32'hDEADBEEF, 32'h00001008, 0, 2, 0, 0, 0, 1, 3);
        vecs[5]  = mk(0, 0, 0, 32'h0,        32'hFFFFF004, 0, 1, 0, 0, 0, 1, 3);
        vecs[6]  = mk(1, 0, 0, 32'h0,        32'h00001008, 0, 2, 0, 0, 0, 1, 3);
        vecs[7]  = mk(0, 1, 0, 32'h11111111, 32'h0,        1, 0, 1, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 1, 1, 1, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 1, 1, 1, 0, 0, 1);
        vecs[10] = mk(1, 1, 1, 32'h22222222, 32'h0,        1, 1, 1, 1, 0, 0, 1);
        vecs[11] = mk(0, 0, 0, 32'h0,        32'h0000000C, 0, 3, 0, 0, 0, 1, 2);
        vecs[12] = mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 2);
        vecs[13] = mk(0, 1, 0, 32'hA0000000, 32'h0,        1, 0, 1, 1, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 32'hA0000001, 32'h0,        1, 1, 1, 1, 0, 0, 1);
        vecs[15] = mk(0, 1, 0, 32'hA0000002, 32'h0,        1, 2, 1, 1, 0, 0, 2);
        vecs[16] = mk(0, 1, 0, 32'hA0000003, 32'h0,        1, 3, 1, 1, 0, 0, 3);
        vecs[17] = mk(0, 1, 0, 32'hBBBBBBBB, 32'h0,        0, 0, 0, 0, 1, 0, 4);
        vecs[18] = mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 4);
        vecs[19] = mk(0, 1, 0, 32'hC0000000, 32'h0,        1, 0, 1, 1, 0, 0, 0);
        vecs[20] = mk(0, 1, 0, 32'hC0000001, 32'h0,        1, 1, 1, 1, 0, 0, 1);
        vecs[21] = mk(0, 1, 0, 32'hC0000002, 32'h0,        1, 2, 1, 1, 0, 0, 2);
        vecs[22] = mk(0, 1, 1, 32'hC0000003, 32'h0,        1, 3, 1, 1, 0, 0, 3);
        vecs[23] = mk(0, 0, 0, 32'h0,        32'h00001008, 0, 2, 0, 0, 0, 1, 4);
        vecs[24] = mk(1, 1, 0, 32'h55555555, 32'h0,        0, 0, 0, 0, 0, 1, 4);
        vecs[25] = mk(0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 0, 0, 0);

        // Reset state, with start and host_valid already asserted.
        rst = 1'b0;
        drive(1, 1, 0, 32'h12345678, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 0, 32'h0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a load: two words, then rst between edges.
        apply("mid0", mk(0, 1, 0, 32'hD0000000, 32'h0, 1, 0, 1, 1, 0, 0, 0));
        apply("mid1", mk(0, 1, 0, 32'hD0000001, 32'h0, 1, 1, 1, 1, 0, 0, 1));
        #1;
        check("mid.pre_rst.imem_we", 32'(imem_we), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_outs("mid.rst", 0, 0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("post_rst%0d", i),
                  mk(0, 1, 0, 32'hE0000000 + 32'(i), 32'h0, 0, 0, 0, 0, 0, 0, 0));
        end

        // Random phase; the DUT is back in its post-reset idle state.
        m_loading = 0; m_running = 0; m_errored = 0; m_n = 0;
        for (int i = 0; i < 1500; i++) begin
            bit          s, v, l;
            logic [31:0] d, f;
            int          exp_addr;
            s = ($urandom_range(0, 7) == 0);
            v = $urandom_range(0, 1) == 1;
            l = ($urandom_range(0, 3) == 0);
            d = $urandom;
            f = $urandom;
            drive(s, v, l, d, f);
            exp_addr = m_running ? int'(f[3:2]) : (m_n % DEPTH);
            @(negedge clk);
            check_outs($sformatf("rnd%0d", i), m_loading && v, exp_addr, d,
                       m_loading, m_loading, m_errored, m_running, m_n);
            @(posedge clk);
            #1;
            if (m_loading) begin
                if (v) begin
                    m_n++;
                    if (l) begin
                        m_loading = 0;
                        m_running = 1;
                    end else if (m_n == DEPTH) begin
                        m_loading = 0;
                        m_errored = 1;
                    end
                end
            end else if (s) begin
                m_loading = 1;
                m_running = 0;
                m_errored = 0;
                m_n       = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
